// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller.
// State encodings are visible on hz_o_state for debug.
package pipeline_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ALU   = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline stages and the hazard controller.
// slave = controller side, master = the stages (or a testbench) driving it.
interface pipeline_ctrl_if #(
    parameter int AWIDTH    = 5,
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 16
);
    logic                 hz_i_ce;
    logic                 hz_i_de_valid;
    logic [AWIDTH-1:0]    hz_i_de_addr_rs1;
    logic [AWIDTH-1:0]    hz_i_de_addr_rs2;
    logic [AWIDTH-1:0]    hz_i_ex_addr_rd;
    logic                 hz_i_ex_we_reg;
    logic                 hz_i_ex_is_load;
    logic                 hz_i_ex_change_pc;
    logic [PC_WIDTH-1:0]  hz_i_ex_next_pc;
    logic                 hz_i_alu_stall;

    logic                 hz_o_fi_ce;
    logic                 hz_o_fi_stall;
    logic                 hz_o_fi_flush;
    logic                 hz_o_ds_stall;
    logic                 hz_o_ds_flush;
    logic                 hz_o_pc_load;
    logic [PC_WIDTH-1:0]  hz_o_pc_target;
    logic [1:0]           hz_o_state;
    logic [CNT_WIDTH-1:0] hz_o_stall_cnt;
    logic [CNT_WIDTH-1:0] hz_o_flush_cnt;

    modport slave (
        input  hz_i_ce, hz_i_de_valid, hz_i_de_addr_rs1, hz_i_de_addr_rs2,
               hz_i_ex_addr_rd, hz_i_ex_we_reg, hz_i_ex_is_load,
               hz_i_ex_change_pc, hz_i_ex_next_pc, hz_i_alu_stall,
        output hz_o_fi_ce, hz_o_fi_stall, hz_o_fi_flush, hz_o_ds_stall,
               hz_o_ds_flush, hz_o_pc_load, hz_o_pc_target, hz_o_state,
               hz_o_stall_cnt, hz_o_flush_cnt
    );

    modport master (
        output hz_i_ce, hz_i_de_valid, hz_i_de_addr_rs1, hz_i_de_addr_rs2,
               hz_i_ex_addr_rd, hz_i_ex_we_reg, hz_i_ex_is_load,
               hz_i_ex_change_pc, hz_i_ex_next_pc, hz_i_alu_stall,
        input  hz_o_fi_ce, hz_o_fi_stall, hz_o_fi_flush, hz_o_ds_stall,
               hz_o_ds_flush, hz_o_pc_load, hz_o_pc_target, hz_o_state,
               hz_o_stall_cnt, hz_o_flush_cnt
    );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detect: a load in execute writes a register that decode reads.
// x0 is hardwired zero, so a load targeting it can never create a dependency.
module hazard_detect #(
    parameter int AWIDTH = 5
) (
    input  logic              de_valid,
    input  logic [AWIDTH-1:0] de_addr_rs1,
    input  logic [AWIDTH-1:0] de_addr_rs2,
    input  logic [AWIDTH-1:0] ex_addr_rd,
    input  logic              ex_we_reg,
    input  logic              ex_is_load,
    output logic              lu
);
    always_comb begin
        lu = de_valid & ex_is_load & ex_we_reg
           & (ex_addr_rd != '0)
           & ((ex_addr_rd == de_addr_rs1) | (ex_addr_rd == de_addr_rs2));
    end
endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for fetch/decode/execute: stalls on load-use
// and multi-cycle ALU, flushes and redirects the PC on execute branch requests.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_RUN   | normal flow, fetch follows global ce, hazards detected
// ST_LOAD  | one-cycle bubble for a load-use dependency
// ST_ALU   | hold fetch/decode while the multi-cycle ALU is busy
// ST_FLUSH | discard fetch/decode for FLUSH_CYCLES after a redirect
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int AWIDTH       = 5,
    parameter int PC_WIDTH     = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic          hz_clk,
    input  logic          hz_rst,
    pipeline_ctrl_if.slave hz_bus
);
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    logic                 lu;
    logic                 redirect_ok;
    logic                 enter_flush;

    state_e               state_q, state_d;
    logic [FW-1:0]        fcnt_q, fcnt_d;
    logic                 fi_ce_q, fi_ce_d;
    logic                 fi_stall_q, fi_stall_d;
    logic                 fi_flush_q, fi_flush_d;
    logic                 pc_load_q, pc_load_d;
    logic [PC_WIDTH-1:0]  pc_target_q, pc_target_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    hazard_detect #(.AWIDTH(AWIDTH)) u_hazard_detect (
        .de_valid    (hz_bus.hz_i_de_valid),
        .de_addr_rs1 (hz_bus.hz_i_de_addr_rs1),
        .de_addr_rs2 (hz_bus.hz_i_de_addr_rs2),
        .ex_addr_rd  (hz_bus.hz_i_ex_addr_rd),
        .ex_we_reg   (hz_bus.hz_i_ex_we_reg),
        .ex_is_load  (hz_bus.hz_i_ex_is_load),
        .lu          (lu)
    );

    assign redirect_ok = hz_bus.hz_i_ex_change_pc & ~hz_bus.hz_i_alu_stall;

    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        enter_flush = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (hz_bus.hz_i_ce) begin
                    if (redirect_ok)               enter_flush = 1'b1;
                    else if (hz_bus.hz_i_alu_stall) state_d    = ST_ALU;
                    else if (lu)                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (redirect_ok) enter_flush = 1'b1;
                else             state_d     = ST_RUN;
            end
            ST_ALU: begin
                if (!hz_bus.hz_i_alu_stall) begin
                    if (hz_bus.hz_i_ex_change_pc) enter_flush = 1'b1;
                    else                          state_d     = ST_RUN;
                end
            end
            ST_FLUSH: begin
                // Redirect requests here come from instructions being flushed.
                if (fcnt_q == '0) state_d = ST_RUN;
                else              fcnt_d  = fcnt_q - FW'(1);
            end
            default: state_d = ST_RUN;
        endcase

        if (enter_flush) begin
            state_d = ST_FLUSH;
            fcnt_d  = FW'(FLUSH_CYCLES - 1);
        end

        pc_load_d   = enter_flush;
        pc_target_d = enter_flush ? hz_bus.hz_i_ex_next_pc : pc_target_q;

        // Outputs follow the next state so they line up with hz_o_state.
        fi_ce_d     = (state_d == ST_RUN) ? hz_bus.hz_i_ce : 1'b1;
        fi_stall_d  = (state_d == ST_LOAD) | (state_d == ST_ALU);
        fi_flush_d  = (state_d == ST_FLUSH);

        stall_cnt_d = stall_cnt_q;
        if (fi_stall_d && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);

        flush_cnt_d = flush_cnt_q;
        if (enter_flush && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge hz_clk) begin
        if (hz_rst) begin
            state_q     <= ST_RUN;
            fcnt_q      <= '0;
            fi_ce_q     <= 1'b0;
            fi_stall_q  <= 1'b0;
            fi_flush_q  <= 1'b0;
            pc_load_q   <= 1'b0;
            pc_target_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            fi_ce_q     <= fi_ce_d;
            fi_stall_q  <= fi_stall_d;
            fi_flush_q  <= fi_flush_d;
            pc_load_q   <= pc_load_d;
            pc_target_q <= pc_target_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz_bus.hz_o_fi_ce     = fi_ce_q;
    assign hz_bus.hz_o_fi_stall  = fi_stall_q;
    assign hz_bus.hz_o_ds_stall  = fi_stall_q;
    assign hz_bus.hz_o_fi_flush  = fi_flush_q;
    assign hz_bus.hz_o_ds_flush  = fi_flush_q;
    assign hz_bus.hz_o_pc_load   = pc_load_q;
    assign hz_bus.hz_o_pc_target = pc_target_q;
    assign hz_bus.hz_o_state     = state_q;
    assign hz_bus.hz_o_stall_cnt = stall_cnt_q;
    assign hz_bus.hz_o_flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scenario bench for pipeline_ctrl: directed cases against hand-derived values
// plus a randomized run against a cycle-level behavioural model.
module tb_pipeline_ctrl;
    localparam int AW    = 5;
    localparam int PW    = 32;
    localparam int FC    = 2;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic hz_clk = 1'b0;
    logic hz_rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 hz_clk = ~hz_clk;

    pipeline_ctrl_if #(.AWIDTH(AW), .PC_WIDTH(PW), .CNT_WIDTH(CW)) bus ();

    pipeline_ctrl #(.AWIDTH(AW), .PC_WIDTH(PW), .FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
        .hz_clk (hz_clk),
        .hz_rst (hz_rst),
        .hz_bus (bus.slave)
    );

    // Reference model: mode 0 run, 1 load bubble, 2 alu wait, 3 flushing.
    int          m_mode = 0;
    int          m_left = 0;
    int          m_stall = 0;
    int          m_flush = 0;
    bit          m_fi_ce = 0;
    bit          m_pc_load = 0;
    logic [PW-1:0] m_target = '0;

    function automatic bit model_lu();
        return bus.hz_i_de_valid && bus.hz_i_ex_is_load && bus.hz_i_ex_we_reg &&
               (bus.hz_i_ex_addr_rd != 0) &&
               (bus.hz_i_ex_addr_rd == bus.hz_i_de_addr_rs1 ||
                bus.hz_i_ex_addr_rd == bus.hz_i_de_addr_rs2);
    endfunction

    task automatic model_step();
        bit cp = bus.hz_i_ex_change_pc;
        bit as = bus.hz_i_alu_stall;
        bit go_flush = 0;
        int nm = m_mode;
        if (hz_rst) begin
            m_mode = 0; m_left = 0; m_stall = 0; m_flush = 0;
            m_fi_ce = 0; m_pc_load = 0; m_target = '0;
            return;
        end
        if (m_mode == 0) begin
            if (bus.hz_i_ce) begin
                if (cp && !as) go_flush = 1;
                else if (as)   nm = 2;
                else if (model_lu()) nm = 1;
            end
        end else if (m_mode == 1) begin
            if (cp && !as) go_flush = 1; else nm = 0;
        end else if (m_mode == 2) begin
            if (!as) begin
                if (cp) go_flush = 1; else nm = 0;
            end
        end else begin
            if (m_left == 0) nm = 0; else m_left = m_left - 1;
        end
        if (go_flush) begin
            nm = 3;
            m_left = FC - 1;
            m_target = bus.hz_i_ex_next_pc;
            if (m_flush < CMAX) m_flush++;
        end
        if ((nm == 1 || nm == 2) && m_stall < CMAX) m_stall++;
        m_mode = nm;
        m_pc_load = go_flush;
        m_fi_ce = (nm == 0) ? bus.hz_i_ce : 1'b1;
    endtask

    task automatic tick();
        @(posedge hz_clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        bus.hz_i_de_valid = 0; bus.hz_i_de_addr_rs1 = '0; bus.hz_i_de_addr_rs2 = '0;
        bus.hz_i_ex_addr_rd = '0; bus.hz_i_ex_we_reg = 0; bus.hz_i_ex_is_load = 0;
        bus.hz_i_ex_change_pc = 0; bus.hz_i_ex_next_pc = '0; bus.hz_i_alu_stall = 0;
        bus.hz_i_ce = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        hz_rst = 1;
        tick();
        hz_rst = 0;
    endtask

    task automatic set_load_use(input logic [AW-1:0] rd);
        bus.hz_i_de_valid = 1; bus.hz_i_ex_is_load = 1; bus.hz_i_ex_we_reg = 1;
        bus.hz_i_ex_addr_rd = rd; bus.hz_i_de_addr_rs1 = 5'd5; bus.hz_i_de_addr_rs2 = 5'd9;
    endtask

    task automatic test_reset();
        idle_inputs();
        hz_rst = 1;
        tick(); tick();
        checks++;
        if ({bus.hz_o_fi_ce, bus.hz_o_fi_stall, bus.hz_o_fi_flush, bus.hz_o_ds_stall,
             bus.hz_o_ds_flush, bus.hz_o_pc_load} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 000000", {bus.hz_o_fi_ce,
                     bus.hz_o_fi_stall, bus.hz_o_fi_flush, bus.hz_o_ds_stall,
                     bus.hz_o_ds_flush, bus.hz_o_pc_load});
        end
        checks++;
        if (bus.hz_o_state !== 2'd0 || bus.hz_o_pc_target !== '0 ||
            bus.hz_o_stall_cnt !== '0 || bus.hz_o_flush_cnt !== '0) begin
            failures++;
            $display("FAIL reset_regs: got state=%0d tgt=%0h sc=%0d fc=%0d expected all 0",
                     bus.hz_o_state, bus.hz_o_pc_target, bus.hz_o_stall_cnt, bus.hz_o_flush_cnt);
        end
        hz_rst = 0;
        tick();
        checks++;
        if (bus.hz_o_fi_ce !== 1'b1 || bus.hz_o_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_release: got fi_ce=%b state=%0d expected 1/0",
                     bus.hz_o_fi_ce, bus.hz_o_state);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_use(5'd5);
        tick();
        idle_inputs();
        checks++;
        if (bus.hz_o_state !== 2'd1 || bus.hz_o_fi_stall !== 1'b1 || bus.hz_o_ds_stall !== 1'b1) begin
            failures++;
            $display("FAIL lu_stall: got state=%0d fs=%b ds=%b expected 1/1/1",
                     bus.hz_o_state, bus.hz_o_fi_stall, bus.hz_o_ds_stall);
        end
        tick();
        checks++;
        if (bus.hz_o_state !== 2'd0 || bus.hz_o_fi_stall !== 1'b0 || bus.hz_o_stall_cnt !== 4'd1) begin
            failures++;
            $display("FAIL lu_release: got state=%0d fs=%b sc=%0d expected 0/0/1",
                     bus.hz_o_state, bus.hz_o_fi_stall, bus.hz_o_stall_cnt);
        end
        set_load_use(5'd0);
        bus.hz_i_de_addr_rs1 = 5'd0;
        tick();
        idle_inputs();
        checks++;
        if (bus.hz_o_state !== 2'd0 || bus.hz_o_fi_stall !== 1'b0 || bus.hz_o_stall_cnt !== 4'd1) begin
            failures++;
            $display("FAIL lu_x0: got state=%0d fs=%b sc=%0d expected 0/0/1",
                     bus.hz_o_state, bus.hz_o_fi_stall, bus.hz_o_stall_cnt);
        end
    endtask

    task automatic test_alu();
        int seen = 0;
        do_reset();
        bus.hz_i_alu_stall = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) bus.hz_i_alu_stall = 0;
            if (bus.hz_o_state == 2'd2 && bus.hz_o_fi_stall && bus.hz_o_ds_stall) seen++;
        end
        checks++;
        if (seen != 4) begin
            failures++;
            $display("FAIL alu_cycles: got %0d stalled cycles expected 4", seen);
        end
        tick();
        checks++;
        if (bus.hz_o_state !== 2'd0 || bus.hz_o_stall_cnt !== 4'd4) begin
            failures++;
            $display("FAIL alu_release: got state=%0d sc=%0d expected 0/4",
                     bus.hz_o_state, bus.hz_o_stall_cnt);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        bus.hz_i_ex_change_pc = 1; bus.hz_i_ex_next_pc = 32'h100;
        tick();
        bus.hz_i_ex_next_pc = 32'h200;
        checks++;
        if (bus.hz_o_pc_load !== 1'b1 || bus.hz_o_pc_target !== 32'h100 || bus.hz_o_state !== 2'd3 ||
            bus.hz_o_fi_flush !== 1'b1 || bus.hz_o_ds_flush !== 1'b1 || bus.hz_o_flush_cnt !== 4'd1) begin
            failures++;
            $display("FAIL redir_enter: got pl=%b tgt=%0h st=%0d ff=%b df=%b fc=%0d expected 1/100/3/1/1/1",
                     bus.hz_o_pc_load, bus.hz_o_pc_target, bus.hz_o_state, bus.hz_o_fi_flush,
                     bus.hz_o_ds_flush, bus.hz_o_flush_cnt);
        end
        tick();
        bus.hz_i_ex_change_pc = 0;
        checks++;
        if (bus.hz_o_pc_load !== 1'b0 || bus.hz_o_pc_target !== 32'h100 || bus.hz_o_fi_flush !== 1'b1 ||
            bus.hz_o_flush_cnt !== 4'd1) begin
            failures++;
            $display("FAIL redir_ignore: got pl=%b tgt=%0h ff=%b fc=%0d expected 0/100/1/1",
                     bus.hz_o_pc_load, bus.hz_o_pc_target, bus.hz_o_fi_flush, bus.hz_o_flush_cnt);
        end
        tick();
        checks++;
        if (bus.hz_o_state !== 2'd0 || bus.hz_o_fi_flush !== 1'b0 || bus.hz_o_ds_flush !== 1'b0 ||
            bus.hz_o_pc_target !== 32'h100) begin
            failures++;
            $display("FAIL redir_done: got st=%0d ff=%b df=%b tgt=%0h expected 0/0/0/100",
                     bus.hz_o_state, bus.hz_o_fi_flush, bus.hz_o_ds_flush, bus.hz_o_pc_target);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        set_load_use(5'd5);
        bus.hz_i_ex_change_pc = 1; bus.hz_i_ex_next_pc = 32'h40; bus.hz_i_alu_stall = 1;
        tick();
        checks++;
        if (bus.hz_o_state !== 2'd2 || bus.hz_o_pc_load !== 1'b0) begin
            failures++;
            $display("FAIL sim_alu_first: got st=%0d pl=%b expected 2/0", bus.hz_o_state, bus.hz_o_pc_load);
        end
        bus.hz_i_alu_stall = 0;
        tick();
        checks++;
        if (bus.hz_o_state !== 2'd3 || bus.hz_o_pc_load !== 1'b1 || bus.hz_o_pc_target !== 32'h40) begin
            failures++;
            $display("FAIL sim_alu_to_flush: got st=%0d pl=%b tgt=%0h expected 3/1/40",
                     bus.hz_o_state, bus.hz_o_pc_load, bus.hz_o_pc_target);
        end
        do_reset();
        set_load_use(5'd5);
        bus.hz_i_ex_change_pc = 1; bus.hz_i_ex_next_pc = 32'h80;
        tick();
        checks++;
        if (bus.hz_o_state !== 2'd3 || bus.hz_o_fi_stall !== 1'b0 || bus.hz_o_pc_target !== 32'h80) begin
            failures++;
            $display("FAIL sim_flush_over_lu: got st=%0d fs=%b tgt=%0h expected 3/0/80",
                     bus.hz_o_state, bus.hz_o_fi_stall, bus.hz_o_pc_target);
        end
        idle_inputs();
    endtask

    task automatic test_reset_in_flush();
        do_reset();
        bus.hz_i_ex_change_pc = 1; bus.hz_i_ex_next_pc = 32'h1234;
        tick();
        idle_inputs();
        hz_rst = 1;
        tick();
        hz_rst = 0;
        checks++;
        if (bus.hz_o_state !== 2'd0 || bus.hz_o_pc_load !== 1'b0 || bus.hz_o_fi_flush !== 1'b0 ||
            bus.hz_o_flush_cnt !== '0 || bus.hz_o_pc_target !== '0) begin
            failures++;
            $display("FAIL rst_in_flush: got st=%0d pl=%b ff=%b fc=%0d tgt=%0h expected 0/0/0/0/0",
                     bus.hz_o_state, bus.hz_o_pc_load, bus.hz_o_fi_flush, bus.hz_o_flush_cnt,
                     bus.hz_o_pc_target);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        bus.hz_i_alu_stall = 1;
        repeat (20) tick();
        checks++;
        if (bus.hz_o_stall_cnt !== 4'd15 || bus.hz_o_state !== 2'd2) begin
            failures++;
            $display("FAIL stall_sat: got sc=%0d st=%0d expected 15/2", bus.hz_o_stall_cnt, bus.hz_o_state);
        end
        bus.hz_i_alu_stall = 0;
        tick();
        checks++;
        if (bus.hz_o_stall_cnt !== 4'd15 || bus.hz_o_state !== 2'd0) begin
            failures++;
            $display("FAIL stall_sat_hold: got sc=%0d st=%0d expected 15/0", bus.hz_o_stall_cnt, bus.hz_o_state);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            hz_rst                = ($urandom_range(0, 79) == 0);
            bus.hz_i_ce           = ($urandom_range(0, 7) != 0);
            bus.hz_i_de_valid     = ($urandom_range(0, 3) != 0);
            bus.hz_i_de_addr_rs1  = AW'($urandom_range(0, 3));
            bus.hz_i_de_addr_rs2  = AW'($urandom_range(0, 3));
            bus.hz_i_ex_addr_rd   = AW'($urandom_range(0, 3));
            bus.hz_i_ex_we_reg    = ($urandom_range(0, 3) != 0);
            bus.hz_i_ex_is_load   = ($urandom_range(0, 1) != 0);
            bus.hz_i_ex_change_pc = ($urandom_range(0, 5) == 0);
            bus.hz_i_ex_next_pc   = $urandom;
            bus.hz_i_alu_stall    = ($urandom_range(0, 4) == 0);
            tick();
            checks++;
            if (bus.hz_o_state !== 2'(m_mode) || bus.hz_o_fi_ce !== m_fi_ce ||
                bus.hz_o_pc_load !== m_pc_load || bus.hz_o_pc_target !== m_target) begin
                failures++;
                $display("FAIL rand_ctrl[%0d]: got st=%0d ce=%b pl=%b tgt=%0h expected %0d/%b/%b/%0h", n,
                         bus.hz_o_state, bus.hz_o_fi_ce, bus.hz_o_pc_load, bus.hz_o_pc_target,
                         m_mode, m_fi_ce, m_pc_load, m_target);
            end
            checks++;
            if (bus.hz_o_fi_stall !== (m_mode == 1 || m_mode == 2) ||
                bus.hz_o_ds_stall !== (m_mode == 1 || m_mode == 2) ||
                bus.hz_o_fi_flush !== (m_mode == 3) || bus.hz_o_ds_flush !== (m_mode == 3)) begin
                failures++;
                $display("FAIL rand_hold[%0d]: got fs=%b ds=%b ff=%b df=%b for model state %0d", n,
                         bus.hz_o_fi_stall, bus.hz_o_ds_stall, bus.hz_o_fi_flush, bus.hz_o_ds_flush, m_mode);
            end
            checks++;
            if (bus.hz_o_stall_cnt !== CW'(m_stall) || bus.hz_o_flush_cnt !== CW'(m_flush)) begin
                failures++;
                $display("FAIL rand_cnt[%0d]: got sc=%0d fc=%0d expected %0d/%0d", n,
                         bus.hz_o_stall_cnt, bus.hz_o_flush_cnt, m_stall, m_flush);
            end
        end
        hz_rst = 0;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_load_use();
        test_alu();
        test_redirect();
        test_simultaneous();
        test_reset_in_flush();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
